// File: rtl/countdown_start_controller_pkg.sv
// Shared types and seven-segment encoding for the countdown start controller.
// Segment patterns are stored active-high and inverted once for the board's active-low digit.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam int ROUND_W = 4;
    localparam int SEG_W   = 8;

    // Bit order of the digit bus: {dp,g,f,e,d,c,b,a}
    localparam int SEG_DP_BIT = 7;
    localparam int SEG_A_BIT  = 0;

    localparam logic SEG_ACTIVE_LOW = 1'b1;

    localparam logic [SEG_W-1:0] SEG_FAULT = 8'b1000_1110;

    function automatic logic [SEG_W-1:0] IntToSeg(input logic [ROUND_W-1:0] value);
        logic [SEG_W-1:0] lit;
        case (value)
            4'd0:    lit = 8'h3F;
            4'd1:    lit = 8'h06;
            4'd2:    lit = 8'h5B;
            4'd3:    lit = 8'h4F;
            4'd4:    lit = 8'h66;
            4'd5:    lit = 8'h6D;
            4'd6:    lit = 8'h7D;
            4'd7:    lit = 8'h07;
            4'd8:    lit = 8'h7F;
            4'd9:    lit = 8'h6F;
            default: lit = 8'h00;
        endcase
        lit[SEG_DP_BIT] = 1'b0;
        lit[SEG_A_BIT]  = lit[SEG_A_BIT];
        return SEG_ACTIVE_LOW ? ~lit : lit;
    endfunction

endpackage

// File: rtl/countdown_start_controller_edge_sync.sv
// Multi-flop synchronizer followed by a registered rising-edge detector.
// Produces a single-cycle pulse per low-to-high transition of an asynchronous level.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;
    logic                   pulse_r;

    // Synchronize the level, remember its previous value and register the rising edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r  <= '0;
            prev_r  <= 1'b0;
            pulse_r <= 1'b0;
        end else begin
            sync_r  <= {sync_r[SYNC_STAGES-2:0], din};
            prev_r  <= sync_r[SYNC_STAGES-1];
            pulse_r <= sync_r[SYNC_STAGES-1] & ~prev_r;
        end
    end

    assign pulse = pulse_r;

endmodule

// File: rtl/countdown_start_controller.sv
// Initiator side of the countdown timer handshake: button-driven start pulse,
// done wait with a 1 Hz watchdog, and a round counter shown on one digit.
module countdown_start_controller
    import counter_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 8,
    parameter int MAX_ROUNDS    = 9,
    parameter int SYNC_STAGES   = 2
) (
    input  logic               Clk100M,
    input  logic               Rst,
    input  logic               button,
    input  logic               Clk1Hz,
    input  logic               doneCounting,
    output logic               start,
    output logic               busy,
    output logic               timeout,
    output logic [ROUND_W-1:0] rounds,
    output logic [SEG_W-1:0]   seg
);

    localparam logic [3:0]         TIMEOUT_LIM = 4'(TIMEOUT_TICKS);
    localparam logic [ROUND_W-1:0] ROUND_MAX   = ROUND_W'(MAX_ROUNDS);

    logic btn_pulse_s;
    logic tick_pulse_s;

    state_t             state_r;
    logic               start_r;
    logic               busy_r;
    logic               timeout_r;
    logic [ROUND_W-1:0] rounds_r;
    logic [3:0]         tick_cnt_r;
    logic [SEG_W-1:0]   seg_r;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_btn_sync (
        .clk   (Clk100M),
        .rst   (Rst),
        .din   (button),
        .pulse (btn_pulse_s)
    );

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_tick_sync (
        .clk   (Clk100M),
        .rst   (Rst),
        .din   (Clk1Hz),
        .pulse (tick_pulse_s)
    );

    // Handshake state machine with registered start/busy/timeout, watchdog and round count
    always_ff @(posedge Clk100M or posedge Rst) begin
        if (Rst) begin
            state_r    <= IDLE;
            start_r    <= 1'b0;
            busy_r     <= 1'b0;
            timeout_r  <= 1'b0;
            rounds_r   <= '0;
            tick_cnt_r <= 4'd0;
        end else begin
            start_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (btn_pulse_s) begin
                        state_r <= START;
                        start_r <= 1'b1;
                        busy_r  <= 1'b1;
                    end
                end
                START: begin
                    state_r    <= WAIT;
                    tick_cnt_r <= 4'd0;
                end
                WAIT: begin
                    // A done pulse beats a coincident final tick
                    if (doneCounting) begin
                        state_r  <= IDLE;
                        busy_r   <= 1'b0;
                        rounds_r <= (rounds_r == ROUND_MAX) ? '0 : rounds_r + 4'd1;
                    end else if (tick_pulse_s) begin
                        tick_cnt_r <= tick_cnt_r + 4'd1;
                        if ((tick_cnt_r + 4'd1) == TIMEOUT_LIM) begin
                            state_r   <= FAULT;
                            busy_r    <= 1'b0;
                            timeout_r <= 1'b1;
                        end
                    end
                end
                FAULT: begin
                    if (btn_pulse_s) begin
                        state_r   <= IDLE;
                        timeout_r <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    busy_r    <= 1'b0;
                    timeout_r <= 1'b0;
                end
            endcase
        end
    end

    // Digit register: fault glyph while faulted, otherwise the round count
    always_ff @(posedge Clk100M or posedge Rst) begin
        if (Rst) begin
            seg_r <= IntToSeg(4'd0);
        end else if (state_r == FAULT) begin
            seg_r <= SEG_FAULT;
        end else begin
            seg_r <= IntToSeg(rounds_r);
        end
    end

    assign start   = start_r;
    assign busy    = busy_r;
    assign timeout = timeout_r;
    assign rounds  = rounds_r;
    assign seg     = seg_r;

endmodule

// File: tb/tb_countdown_start_controller.sv
// Scoreboard bench: stimulus pushes expected output snapshots, a negedge monitor
// compares every change of the output bus against the queue head.
module tb_countdown_start_controller;

    logic       clk;
    logic       rst;
    logic       button;
    logic       clk1hz;
    logic       done;
    logic       start;
    logic       busy;
    logic       timeout;
    logic [3:0] rounds;
    logic [7:0] seg;

    typedef struct packed {
        logic       st;
        logic       bz;
        logic       to;
        logic [3:0] rd;
        logic [7:0] sg;
    } snap_t;

    typedef struct {
        snap_t s;
        int    c;
    } exp_t;

    exp_t  exp_q[$];
    int    checks;
    int    errors;
    int    cyc;
    bit    mon_en;
    bit    have_prev;
    snap_t prev;

    countdown_start_controller dut (
        .Clk100M      (clk),
        .Rst          (rst),
        .button       (button),
        .Clk1Hz       (clk1hz),
        .doneCounting (done),
        .start        (start),
        .busy         (busy),
        .timeout      (timeout),
        .rounds       (rounds),
        .seg          (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] seg_of(input int v);
        case (v)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic push(input logic st, input logic bz, input logic to,
                        input int rd, input logic [7:0] sg, input int c);
        exp_t e;
        e.s = {st, bz, to, 4'(rd), sg};
        e.c = c;
        exp_q.push_back(e);
    endtask

    // From IDLE with round count r: start pulse 4 edges after the press is sampled
    task automatic press(input int r);
        push(1'b1, 1'b1, 1'b0, r, seg_of(r), cyc + 4);
        push(1'b0, 1'b1, 1'b0, r, seg_of(r), cyc + 5);
        button = 1'b1;
        repeat (8) @(negedge clk);
        button = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic finish_round(input int r, input int nr);
        push(1'b0, 1'b0, 1'b0, nr, seg_of(r), cyc + 1);
        push(1'b0, 1'b0, 1'b0, nr, seg_of(nr), cyc + 2);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic tick();
        clk1hz = 1'b1;
        repeat (6) @(negedge clk);
        clk1hz = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    // Monitor: any change of the output bus must match the next expected snapshot
    always @(negedge clk) begin
        snap_t cur;
        exp_t  e;
        if (mon_en) begin
            cur = {start, busy, timeout, rounds, seg};
            if (!have_prev || cur != prev) begin
                checks = checks + 1;
                if (exp_q.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL unexpected_event cyc=%0d got st=%0b busy=%0b to=%0b rounds=%0d seg=%h, required no change",
                             cyc, cur.st, cur.bz, cur.to, cur.rd, cur.sg);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e.s || (e.c >= 0 && cyc != e.c)) begin
                        errors = errors + 1;
                        $display("FAIL event cyc=%0d got st=%0b busy=%0b to=%0b rounds=%0d seg=%h, required cyc=%0d st=%0b busy=%0b to=%0b rounds=%0d seg=%h",
                                 cyc, cur.st, cur.bz, cur.to, cur.rd, cur.sg,
                                 e.c, e.s.st, e.s.bz, e.s.to, e.s.rd, e.s.sg);
                    end
                end
            end
            prev      = cur;
            have_prev = 1'b1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        mon_en    = 1'b0;
        have_prev = 1'b0;
        rst       = 1'b1;
        button    = 1'b0;
        clk1hz    = 1'b0;
        done      = 1'b0;

        // Reset state
        push(1'b0, 1'b0, 1'b0, 0, 8'hC0, -1);
        repeat (2) @(posedge clk);
        #1 mon_en = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // First round with a long countdown
        press(0);
        repeat (584) @(negedge clk);
        finish_round(0, 1);

        // Spurious done while idle
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        repeat (4) @(negedge clk);

        // Nine more rounds: 2..9 then wrap to 0
        for (int r = 1; r <= 9; r++) begin
            press(r);
            repeat (10) @(negedge clk);
            finish_round(r, (r == 9) ? 0 : r + 1);
        end

        // Watchdog fault after 8 ticks with no done
        press(0);
        repeat (7) tick();
        push(1'b0, 1'b0, 1'b1, 0, seg_of(0), cyc + 4);
        push(1'b0, 1'b0, 1'b1, 0, 8'b1000_1110, cyc + 5);
        tick();
        repeat (5) @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        repeat (5) @(negedge clk);
        push(1'b0, 1'b0, 1'b0, 0, 8'b1000_1110, cyc + 4);
        push(1'b0, 1'b0, 1'b0, 0, seg_of(0), cyc + 5);
        button = 1'b1;
        repeat (8) @(negedge clk);
        button = 1'b0;
        repeat (8) @(negedge clk);

        // Done coincides with the 8th tick: done wins
        press(0);
        repeat (7) tick();
        push(1'b0, 1'b0, 1'b0, 1, seg_of(0), cyc + 4);
        push(1'b0, 1'b0, 1'b0, 1, seg_of(1), cyc + 5);
        clk1hz = 1'b1;
        repeat (3) @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        repeat (2) @(negedge clk);
        clk1hz = 1'b0;
        repeat (6) @(negedge clk);
        press(1);
        finish_round(1, 2);

        // Second press while busy gives no extra start
        press(2);
        button = 1'b1;
        repeat (8) @(negedge clk);
        button = 1'b0;
        repeat (8) @(negedge clk);
        finish_round(2, 3);

        // Reset in the middle of a countdown
        press(3);
        repeat (10) @(negedge clk);
        push(1'b0, 1'b0, 1'b0, 0, seg_of(0), cyc + 1);
        #1 rst = 1'b1;
        #1;
        checks = checks + 1;
        if ({start, busy, timeout, rounds, seg} !== {1'b0, 1'b0, 1'b0, 4'd0, 8'hC0}) begin
            errors = errors + 1;
            $display("FAIL async_reset got st=%0b busy=%0b to=%0b rounds=%0d seg=%h, required 0 0 0 0 c0",
                     start, busy, timeout, rounds, seg);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Button held high for 1000 cycles gives one start
        push(1'b1, 1'b1, 1'b0, 0, seg_of(0), cyc + 4);
        push(1'b0, 1'b1, 1'b0, 0, seg_of(0), cyc + 5);
        button = 1'b1;
        repeat (500) @(negedge clk);
        finish_round(0, 1);
        repeat (495) @(negedge clk);
        button = 1'b0;
        repeat (20) @(negedge clk);

        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL pending_events got %0d outstanding, required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
